// File: rtl/rv_pkg.sv
// Shared definitions for the fetch PC controller: FSM states, redirect-source
// encoding (numeric order equals priority) and the default reset vector.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_REQ      = 2'd1,
        ST_RSP_HOLD = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_e;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    // A candidate displaces the held redirect when it is at least as urgent.
    function automatic logic src_wins(input redir_src_e cand, input redir_src_e held);
        return (cand != SRC_NONE) && (cand >= held);
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-side bundle between pc_ctrl and its environment (redirect sources,
// PC register, instruction memory, decode). Trap lines exist only with PC_CTRL_TRAP_EN.
interface pc_ctrl_if;
`ifdef PC_CTRL_TRAP_EN
    logic        trap_valid;
    logic [31:0] trap_vect;
`endif
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic        pc_hold;
    logic        pc_sel;
    logic [31:0] pc_vect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;

    modport ctrl (
`ifdef PC_CTRL_TRAP_EN
        input  trap_valid,
        input  trap_vect,
`endif
        input  stall,
        input  br_valid,
        input  br_target,
        input  jmp_valid,
        input  jmp_target,
        input  pc,
        input  imem_ack,
        output pc_hold,
        output pc_sel,
        output pc_vect,
        output imem_req,
        output imem_addr,
        output fetch_valid
    );

    modport env (
`ifdef PC_CTRL_TRAP_EN
        output trap_valid,
        output trap_vect,
`endif
        output stall,
        output br_valid,
        output br_target,
        output jmp_valid,
        output jmp_target,
        output pc,
        output imem_ack,
        input  pc_hold,
        input  pc_sel,
        input  pc_vect,
        input  imem_req,
        input  imem_addr,
        input  fetch_valid
    );

endinterface

// File: rtl/pc_ctrl_redirect_arb.sv
// Combinational priority select among same-cycle redirect requests (trap > br > jmp).
module redirect_arb
    import rv_pkg::*;
(
    input  logic        trap_valid_i,
    input  logic [31:0] trap_target_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    output redir_src_e  src_o,
    output logic [31:0] target_o
);

    // Highest-priority valid request wins; the others are dropped.
    always_comb begin
        src_o    = SRC_NONE;
        target_o = 32'h0000_0000;
        if (trap_valid_i) begin
            src_o    = SRC_TRAP;
            target_o = trap_target_i;
        end else if (br_valid_i) begin
            src_o    = SRC_BR;
            target_o = br_target_i;
        end else if (jmp_valid_i) begin
            src_o    = SRC_JMP;
            target_o = jmp_target_i;
        end else begin
            src_o    = SRC_NONE;
            target_o = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch PC controller: sequences instruction-memory requests, holds one pending
// redirect while a fetch is outstanding. Optional trap redirect: PC_CTRL_TRAP_EN.
module pc_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_ctrl_if.ctrl    bus
);

    pc_state_e   state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    redir_src_e  pend_src_q, pend_src_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        trap_valid_s;
    logic [31:0] trap_vect_s;
    redir_src_e  new_src_s;
    logic [31:0] new_target_s;
    redir_src_e  held_src_s;
    redir_src_e  win_src_s;
    logic [31:0] win_target_s;
    logic        win_valid_s;

    logic        pc_hold_s;
    logic        pc_sel_s;
    logic [31:0] pc_vect_s;
    logic        imem_req_s;
    logic        fetch_valid_s;

`ifdef PC_CTRL_TRAP_EN
    assign trap_valid_s = bus.trap_valid;
    assign trap_vect_s  = bus.trap_vect;
`else
    assign trap_valid_s = 1'b0;
    assign trap_vect_s  = 32'h0000_0000;
`endif

    redirect_arb u_arb (
        .trap_valid_i  (trap_valid_s),
        .trap_target_i (trap_vect_s),
        .br_valid_i    (bus.br_valid),
        .br_target_i   (bus.br_target),
        .jmp_valid_i   (bus.jmp_valid),
        .jmp_target_i  (bus.jmp_target),
        .src_o         (new_src_s),
        .target_o      (new_target_s)
    );

    assign held_src_s = pend_valid_q ? pend_src_q : SRC_NONE;
    assign win_valid_s = (win_src_s != SRC_NONE);

    // Merge the pending redirect with this cycle's request; ties go to the newer one.
    always_comb begin
        win_src_s    = held_src_s;
        win_target_s = pend_target_q;
        if (src_wins(new_src_s, held_src_s)) begin
            win_src_s    = new_src_s;
            win_target_s = new_target_s;
        end else begin
            win_src_s    = held_src_s;
            win_target_s = pend_target_q;
        end
    end

    // Next-state, pending-register update and fetch-side outputs.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_src_d    = pend_src_q;
        pend_target_d = pend_target_q;
        pc_hold_s     = 1'b1;
        pc_sel_s      = 1'b0;
        pc_vect_s     = win_target_s;
        imem_req_s    = 1'b0;
        fetch_valid_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_hold_s    = 1'b0;
                pc_sel_s     = 1'b1;
                pc_vect_s    = RESET_VEC;
                pend_valid_d = 1'b0;
                pend_src_d   = SRC_NONE;
                state_d      = ST_REQ;
            end
            ST_REQ: begin
                imem_req_s = 1'b1;
                if (!bus.imem_ack) begin
                    pc_hold_s     = 1'b1;
                    pend_valid_d  = win_valid_s;
                    pend_src_d    = win_src_s;
                    pend_target_d = win_target_s;
                end else if (win_valid_s) begin
                    // Squash the returning instruction; stall is irrelevant.
                    pc_hold_s    = 1'b0;
                    pc_sel_s     = 1'b1;
                    pc_vect_s    = win_target_s;
                    pend_valid_d = 1'b0;
                    pend_src_d   = SRC_NONE;
                end else if (bus.stall) begin
                    fetch_valid_s = 1'b1;
                    pc_hold_s     = 1'b1;
                    state_d       = ST_RSP_HOLD;
                end else begin
                    fetch_valid_s = 1'b1;
                    pc_hold_s     = 1'b0;
                end
            end
            ST_RSP_HOLD: begin
                if (win_valid_s) begin
                    pc_hold_s    = 1'b0;
                    pc_sel_s     = 1'b1;
                    pc_vect_s    = win_target_s;
                    pend_valid_d = 1'b0;
                    pend_src_d   = SRC_NONE;
                    state_d      = ST_REQ;
                end else if (bus.stall) begin
                    fetch_valid_s = 1'b1;
                    pc_hold_s     = 1'b1;
                end else begin
                    fetch_valid_s = 1'b1;
                    pc_hold_s     = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            default: begin
                state_d      = ST_BOOT;
                pend_valid_d = 1'b0;
                pend_src_d   = SRC_NONE;
            end
        endcase
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pend_valid_q  <= 1'b0;
            pend_src_q    <= SRC_NONE;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_src_q    <= pend_src_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.pc_hold     = pc_hold_s;
    assign bus.pc_sel      = pc_sel_s;
    assign bus.pc_vect     = pc_vect_s;
    assign bus.imem_req    = imem_req_s;
    assign bus.imem_addr   = bus.pc;
    assign bus.fetch_valid = fetch_valid_s;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a fetch-stream reference model queues expected
// per-cycle responses; a negedge monitor pops and compares them.
module tb_pc_ctrl;
    import rv_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
`ifdef PC_CTRL_TRAP_EN
    localparam bit HAS_TRAP = 1'b1;
`else
    localparam bit HAS_TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_ctrl_if bus ();

    pc_ctrl #(.RESET_VEC(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Program counter register owned by the environment.
    logic [31:0] pc_q;
    always @(posedge clk) begin
        if (!bus.pc_hold) pc_q <= bus.pc_sel ? bus.pc_vect : pc_q + 32'd4;
    end
    assign bus.pc = pc_q;

    typedef struct packed {
        logic        req;
        logic        fv;
        logic        hold;
        logic        sel;
        logic [31:0] vect;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 = restarting, 1 = fetch outstanding, 2 = instruction parked.
    int          m_phase;
    logic [31:0] m_addr;
    int          m_best_p;
    logic [31:0] m_best_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input logic a, input logic s,
                        input logic bv, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt,
                        input logic tv, input logic [31:0] tt);
        exp_t        e;
        int          np;
        logic [31:0] nt;
        bus.imem_ack   = a;
        bus.stall      = s;
        bus.br_valid   = bv;
        bus.br_target  = bt;
        bus.jmp_valid  = jv;
        bus.jmp_target = jt;
`ifdef PC_CTRL_TRAP_EN
        bus.trap_valid = tv;
        bus.trap_vect  = tt;
`endif
        np = 0;
        nt = 32'h0;
        if (HAS_TRAP && tv) begin np = 3; nt = tt; end
        else if (bv)        begin np = 2; nt = bt; end
        else if (jv)        begin np = 1; nt = jt; end
        e = '0;
        e.addr = m_addr;
        if (m_phase == 0) begin
            e.sel = 1'b1; e.vect = RV;
            m_addr = RV; m_best_p = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            e.req = 1'b1;
            if (np > 0 && np >= m_best_p) begin m_best_p = np; m_best_t = nt; end
            if (!a) e.hold = 1'b1;
            else if (m_best_p > 0) begin
                e.sel = 1'b1; e.vect = m_best_t;
                m_addr = m_best_t; m_best_p = 0;
            end else if (s) begin
                e.fv = 1'b1; e.hold = 1'b1; m_phase = 2;
            end else begin
                e.fv = 1'b1; m_addr = m_addr + 32'd4;
            end
        end else begin
            if (np > 0) begin
                e.sel = 1'b1; e.vect = nt; m_addr = nt; m_phase = 1;
            end else if (s) begin
                e.fv = 1'b1; e.hold = 1'b1;
            end else begin
                e.fv = 1'b1; m_addr = m_addr + 32'd4; m_phase = 1;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic a, input logic s);
        step(a, s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic reset_outputs();
        chk("rst imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("rst pc_sel", {31'd0, bus.pc_sel}, 32'd1);
        chk("rst pc_hold", {31'd0, bus.pc_hold}, 32'd0);
        chk("rst pc_vect", bus.pc_vect, RV);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        reset_outputs();
        chk("rst pend_valid", {31'd0, dut.pend_valid_q}, 32'd0);
        m_phase = 0;
        m_best_p = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    exp_t me;
    // Monitor: every active cycle the DUT presents a response to compare.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("imem_req", {31'd0, bus.imem_req}, {31'd0, me.req});
            chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, me.fv});
            chk("pc_hold", {31'd0, bus.pc_hold}, {31'd0, me.hold});
            if (!me.hold) chk("pc_sel", {31'd0, bus.pc_sel}, {31'd0, me.sel});
            if (!me.hold && me.sel) chk("pc_vect", bus.pc_vect, me.vect);
            if (me.req) chk("imem_addr", bus.imem_addr, me.addr);
        end
    end

    initial begin
        bus.imem_ack = 1'b0; bus.stall = 1'b0;
        bus.br_valid = 1'b0; bus.br_target = 32'h0;
        bus.jmp_valid = 1'b0; bus.jmp_target = 32'h0;
`ifdef PC_CTRL_TRAP_EN
        bus.trap_valid = 1'b0; bus.trap_vect = 32'h0;
`endif
        m_phase = 0; m_addr = RV; m_best_p = 0; m_best_t = 32'h0;
        rst_n = 1'b0;
        #2;
        reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot, then back-to-back fetches 0,4,8,12.
        idle(1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        // Branch on first wait cycle, ack on third.
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // jmp then br while waiting, and the reverse order.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        // Ack under stall for 3 cycles, then release.
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b0);
        // Redirect while parked overrides stall.
        idle(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b1, 1'b0);
        // Wrap of the sequential address past the top of memory.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        repeat (3) idle(1'b1, 1'b0);
        // Same-cycle trap and branch.
        step(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // Reset with a redirect pending; an ack during boot is ignored.
        step(1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("pend before reset", {31'd0, dut.pend_valid_q}, 32'd1);
        do_reset();
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) == 0, $urandom,
                     $urandom_range(0, 9) == 0, $urandom,
                     $urandom_range(0, 14) == 0, $urandom);
            end
        end
        idle(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, shall be the first fetch address after reset.
REQ-002 Port clk  in  1  shall be the single clock; all state updates on posedge clk.
REQ-003 Port rst_n  in  1  shall be the reset: asynchronous, active-low.
REQ-004 Port stall  in  1  shall be downstream backpressure; 1 = decode cannot accept an instruction.
REQ-005 Ports br_valid/br_target  in  1/32  shall be the execute-stage branch redirect.
REQ-006 Ports jmp_valid/jmp_target  in  1/32  shall be the decode-stage jump redirect.
REQ-007 Ports trap_valid/trap_vect  in  1/32  shall be the trap redirect (present only with PC_CTRL_TRAP_EN).
REQ-008 Port pc  in  32  shall be the current PC from the program counter register.
REQ-009 Ports pc_hold/pc_sel/pc_vect  out  1/1/32  shall drive the program counter's hold, load-select and load vector.
REQ-010 Ports imem_req/imem_addr/imem_ack  out/out/in  1/32/1  shall be the instruction-memory request handshake; imem_addr = pc.
REQ-011 Port fetch_valid  out  1  shall flag that the returned instruction for pc is valid and not squashed.

Function
REQ-012 FSM states shall be BOOT, REQ, RSP_HOLD.
REQ-013 BOOT: pc_sel=1, pc_vect=RESET_VEC, pc_hold=0, imem_req=0; next state REQ unconditionally.
REQ-014 REQ: imem_req=1; while imem_ack=0, pc_hold=1 and imem_req/imem_addr stay stable.
REQ-015 REQ with imem_ack=1, stall=0, no redirect: fetch_valid=1, pc_hold=0, pc_sel=0 (PC+4); stay in REQ.
REQ-016 REQ with imem_ack=1, stall=1: fetch_valid=1, pc_hold=1; go to RSP_HOLD.
REQ-017 RSP_HOLD: imem_req=0, fetch_valid=1, pc_hold=1 until stall=0; that cycle pc_hold=0, PC advances (or redirects), return to REQ.
REQ-018 Redirect priority shall be trap > br > jmp; a same-cycle lower-priority request is discarded.
REQ-019 A redirect in REQ without ack shall be latched into a one-entry pending register (pend_valid, pend_target); a later higher-or-equal-priority redirect overwrites it, a lower one is discarded.
REQ-020 On imem_ack with a pending or same-cycle redirect: fetch_valid=0 (squash), pc_hold=0, pc_sel=1, pc_vect=winning target, pend_valid cleared, stall ignored, stay in REQ.
REQ-021 A redirect in RSP_HOLD shall apply immediately (fetch_valid=0, pc_sel=1, pc_hold=0), clearing pend_valid and overriding stall; next state REQ.
REQ-022 Targets shall be passed unmodified, 32 bits; PC+4 wrap at 32'hFFFF_FFFC to 0 is the counter's natural behaviour, not flagged.
REQ-023 All outputs shall be combinational from state, pending register and inputs; zero-cycle redirect latency on the ack cycle.

Reset
REQ-024 rst_n=0 shall force state=BOOT, pend_valid=0 asynchronously; outputs then imem_req=0, fetch_valid=0, pc_sel=1, pc_vect=RESET_VEC, pc_hold=0.
REQ-025 Reset mid-request shall abandon the outstanding fetch; an ack arriving in BOOT shall be ignored.

Configuration
REQ-026 Macro PC_CTRL_TRAP_EN defined: trap ports exist and take top priority.
REQ-027 Macro undefined: trap ports absent, priority br > jmp, all other behaviour identical.

Structure
REQ-028 Shared package rv_pkg shall hold the FSM state encoding, redirect-source encoding and RESET_VEC default.
REQ-029 Sub-module redirect_arb (combinational priority select of valid/target) is natural; FSM and pending register stay in pc_ctrl.

Verification
REQ-030 Reset release -> one BOOT cycle with pc_vect=0, pc_sel=1, then imem_req=1 with imem_addr=0.
REQ-031 Ack every cycle, stall=0 -> imem_addr 0,4,8,12 on consecutive cycles, fetch_valid=1 each.
REQ-032 Ack on 3rd REQ cycle, br_valid=1/br_target=32'h100 on 1st -> ack cycle fetch_valid=0, pc_vect=32'h100, next imem_addr=32'h100.
REQ-033 jmp 32'h200 then br 32'h300 while waiting -> pending target 32'h300 applied at ack; reversed order -> still 32'h300.
REQ-034 Ack with stall=1 for 3 cycles -> fetch_valid=1 and pc held 4 cycles, imem_req=0 in RSP_HOLD, advance on stall release.
REQ-035 rst_n low mid-REQ with pend_valid=1 -> pend_valid=0, BOOT, restart at RESET_VEC; with PC_CTRL_TRAP_EN, trap+br same cycle -> trap_vect wins.
